// File: rtl/predecode_queue.sv
// Fetch-to-decode instruction queue: circular buffer that predecodes each
// instruction on enqueue and tags it with a branch/jump delay-slot flag.
module predecode_queue #(
    parameter int DEPTH = 4,
    parameter int IW    = 32,
    parameter int PCW   = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IW-1:0]                in_instr,
    input  logic [PCW-1:0]               in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IW-1:0]                out_instr,
    output logic [PCW-1:0]               out_pc,
    output logic [7:0]                   out_class,
    output logic                         out_ds,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           last_cf;
    logic           enq, deq;
    logic [5:0]     op, funct;
    logic [4:0]     rt;
    logic           is_load, is_store;
    logic [7:0]     in_class;

    logic [IW-1:0]  mem_instr [DEPTH];
    logic [PCW-1:0] mem_pc    [DEPTH];
    logic [7:0]     mem_class [DEPTH];
    logic           mem_ds    [DEPTH];

    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign enq = in_valid & in_ready & ~flush;
    assign deq = out_valid & out_ready & ~flush;

    always_comb begin
        op       = in_instr[31:26];
        rt       = in_instr[20:16];
        funct    = in_instr[5:0];
        is_load  = 1'b0;
        is_store = 1'b0;
        in_class = '0;
        case (op)
            6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: is_load  = 1'b1;
            6'b101000, 6'b101001, 6'b101011:                       is_store = 1'b1;
            default: ;
        endcase
        in_class[0] = (op == 6'b000001) || (op[5:2] == 4'b0001);
        in_class[1] = (op[5:1] == 5'b00001) || ((op == 6'b000000) && (funct[5:1] == 5'b00100));
        in_class[2] = is_load;
        in_class[3] = is_store;
        in_class[4] = (op == 6'b000000) && ((funct[5:2] == 4'b0100) || (funct[5:2] == 4'b0110));
        in_class[5] = (op == 6'b010000);
        in_class[6] = (op == 6'b000011) || ((op == 6'b000001) && (rt[4:1] == 4'b1000))
                      || ((op == 6'b000000) && (funct == 6'b001001));
        in_class[7] = !((op[5:4] == 2'b00) || (op == 6'b010000) || is_load || is_store);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            last_cf <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            last_cf <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr  <= wr_ptr + 1'b1;
                last_cf <= in_class[0] | in_class[1];
            end
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage is deliberately left uninitialised; outputs are masked instead.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_instr[wr_ptr] <= in_instr;
            mem_pc[wr_ptr]    <= in_pc;
            mem_class[wr_ptr] <= in_class;
            mem_ds[wr_ptr]    <= last_cf;
        end
    end

    assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
    assign out_pc    = out_valid ? mem_pc[rd_ptr]    : '0;
    assign out_class = out_valid ? mem_class[rd_ptr] : '0;
    assign out_ds    = out_valid ? mem_ds[rd_ptr]    : 1'b0;

endmodule

// File: tb/tb_predecode_queue.sv
// Scoreboard bench for predecode_queue: randomized and directed traffic checked
// against a queue-based reference model of the predecode and delay-slot rules.
module tb_predecode_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          resetn, flush, in_valid, in_ready, out_valid, out_ready, out_ds;
    logic [31:0]   in_instr, in_pc, out_instr, out_pc;
    logic [7:0]    out_class;
    logic [CW-1:0] count;

    predecode_queue #(.DEPTH(DEPTH), .IW(32), .PCW(32)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_class(out_class), .out_ds(out_ds), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [7:0]  cls;
        logic        ds;
    } ent_t;

    ent_t exp_q[$];
    int   model_count = 0;
    logic model_last_cf = 1'b0;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference predecode written straight from the opcode tables.
    function automatic logic [7:0] ref_class(input logic [31:0] i);
        logic [5:0] op, fn;
        logic [4:0] rt;
        logic [7:0] c;
        op = i[31:26];
        rt = i[20:16];
        fn = i[5:0];
        c = '0;
        c[0] = (op == 1) || (op >= 4 && op <= 7);
        c[1] = (op == 2) || (op == 3) || (op == 0 && (fn == 8 || fn == 9));
        c[2] = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
        c[3] = op inside {6'h28, 6'h29, 6'h2B};
        c[4] = (op == 0) && (fn inside {[16:19], [24:27]});
        c[5] = (op == 16);
        c[6] = (op == 3) || (op == 1 && (rt == 16 || rt == 17)) || (op == 0 && fn == 9);
        c[7] = !(op <= 15 || op == 16 || c[2] || c[3]);
        return c;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops [12] = '{6'h01, 6'h04, 6'h05, 6'h07, 6'h02, 6'h03, 6'h10,
                                  6'h20, 6'h23, 6'h28, 6'h2B, 6'h3F};
        logic [5:0]  fns [8]  = '{6'h08, 6'h09, 6'h10, 6'h13, 6'h18, 6'h1B, 6'h14, 6'h21};
        logic [31:0] r;
        r = $urandom;
        case ($urandom % 4)
            0, 1: begin
                r[31:26] = ops[$urandom % 12];
                if (r[31:26] == 6'h01 && $urandom % 2 == 0) r[20:17] = 4'b1000;
            end
            2: begin
                r[31:26] = 6'h00;
                r[5:0]   = fns[$urandom % 8];
            end
            default: ;
        endcase
        return r;
    endfunction

    // Reference model: tracks occupancy and pushes expected entries on enqueue.
    always @(negedge clk) begin
        if (resetn) begin
            logic enq, deq;
            ent_t e;
            check("count", 128'(count), 128'(model_count));
            check("in_ready", 128'(in_ready), 128'(model_count < DEPTH));
            check("out_valid", 128'(out_valid), 128'(model_count != 0));
            enq = in_valid && (model_count < DEPTH) && !flush;
            deq = (model_count != 0) && out_ready && !flush;
            if (flush) begin
                exp_q.delete();
                model_count   = 0;
                model_last_cf = 1'b0;
            end else begin
                if (enq) begin
                    e.instr = in_instr;
                    e.pc    = in_pc;
                    e.cls   = ref_class(in_instr);
                    e.ds    = model_last_cf;
                    model_last_cf = e.cls[0] | e.cls[1];
                    exp_q.push_back(e);
                end
                model_count = model_count + int'(enq) - int'(deq);
            end
        end
    end

    // Monitor: compares the presented head and pops it when it is consumed.
    always @(negedge clk) begin
        if (resetn) begin
            if (!out_valid) begin
                check("masked", {out_instr, out_pc, out_class, 7'd0, out_ds}, '0);
            end else if (!flush) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_head", 128'(out_valid), 128'(0));
                end else begin
                    check("head", {out_instr, out_pc, out_class, 7'd0, out_ds},
                          {exp_q[0].instr, exp_q[0].pc, exp_q[0].cls, 7'd0, exp_q[0].ds});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 32 && model_count != 0; k++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("drain_count", 128'(count), 128'(0));
    endtask

    task automatic single(input logic [31:0] ins, input logic [7:0] cls, input logic ds);
        cyc(1'b1, ins, 32'h8000_0000 + ins, 1'b0, 1'b0);
        check("class_direct", 128'(out_class), 128'(cls));
        check("ds_direct", 128'(out_ds), 128'(ds));
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        resetn = 1'b0;
        in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 128'(count), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_outputs", {out_valid, out_instr, out_pc, out_class, out_ds}, '0);
        #2 resetn = 1'b1;

        cyc(1'b1, 32'h2408_0005, 32'hBFC0_0000, 1'b0, 1'b0);
        check("addiu_valid", 128'(out_valid), 128'(1));
        check("addiu_class", 128'(out_class), 128'(8'h00));
        check("addiu_ds", 128'(out_ds), 128'(0));
        check("addiu_count", 128'(count), 128'(1));
        drain();

        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h2400_0000 + i, 32'h1000 + 4 * i, 1'b0, 1'b0);
        check("full_ready", 128'(in_ready), 128'(0));
        check("full_count", 128'(count), 128'(4));
        cyc(1'b1, 32'h2400_0004, 32'h1010, 1'b1, 1'b0);
        check("after_deq_ready", 128'(in_ready), 128'(1));
        check("after_deq_count", 128'(count), 128'(3));
        cyc(1'b1, 32'h2400_0004, 32'h1010, 1'b0, 1'b0);
        check("refill_count", 128'(count), 128'(4));
        drain();

        single(32'h1000_0003, 8'h01, 1'b0);
        single(32'h0000_0000, 8'h00, 1'b1);
        single(32'h8C82_0000, 8'h04, 1'b0);
        single(32'h0C00_0010, 8'h42, 1'b0);
        single(32'h0411_FFFF, 8'h41, 1'b1);
        single(32'h0000_0018, 8'h10, 1'b1);
        single(32'hFC00_0000, 8'h80, 1'b0);

        cyc(1'b1, 32'h2400_0001, 32'h2000, 1'b0, 1'b0);
        cyc(1'b1, 32'h2400_0002, 32'h2004, 1'b0, 1'b0);
        cyc(1'b1, 32'h1000_0003, 32'h2008, 1'b0, 1'b0);
        check("pre_flush_count", 128'(count), 128'(3));
        cyc(1'b1, 32'h2400_0009, 32'h200C, 1'b1, 1'b1);
        check("flush_count", 128'(count), 128'(0));
        check("flush_valid", 128'(out_valid), 128'(0));
        cyc(1'b1, 32'h0000_0000, 32'h3000, 1'b0, 1'b0);
        check("post_flush_ds", 128'(out_ds), 128'(0));
        drain();

        cyc(1'b1, 32'h2400_0011, 32'h4000, 1'b0, 1'b0);
        cyc(1'b1, 32'h1000_0011, 32'h4004, 1'b0, 1'b0);
        check("pre_reset_count", 128'(count), 128'(2));
        in_valid = 1'b0;
        #1 resetn = 1'b0;
        #1;
        check("async_rst_count", 128'(count), 128'(0));
        check("async_rst_valid", 128'(out_valid), 128'(0));
        check("async_rst_pc", 128'(out_pc), 128'(0));
        exp_q.delete();
        model_count   = 0;
        model_last_cf = 1'b0;
        #1 resetn = 1'b1;

        for (int n = 0; n < 400; n++)
            cyc(($urandom % 4) != 0, rand_instr(), $urandom, ($urandom % 3) != 0, ($urandom % 32) == 0);
        drain();
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/predecode_queue.md
# predecode_queue

Parametrised instruction queue between fetch and decode. Each instruction is predecoded on enqueue and stored with its PC, a class vector and a delay-slot flag, so the decode stage can steer hazards and HILO/CP0 handling without re-decoding the opcode. It decouples fetch from decode stalls with a valid/ready handshake and is cleared by a pipeline flush (exception, ERET, mispredict).

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- IW, 32, instruction width
- PCW, 32, PC width
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all entries and the delay-slot tracker
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  queue accepts an instruction; equals count < DEPTH
- in_instr  in  IW  instruction word
- in_pc  in  PCW  instruction PC
- out_valid  out  1  head entry valid; equals count != 0
- out_ready  in  1  decode consumes the head (low while stallD)
- out_instr  out  IW  head instruction; 0 when out_valid=0
- out_pc  out  PCW  head PC; 0 when out_valid=0
- out_class  out  8  head predecode vector; 0 when out_valid=0
- out_ds  out  1  head is in a branch/jump delay slot; 0 when out_valid=0
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Enqueue fires when in_valid & in_ready & !flush. Dequeue fires when out_valid & out_ready & !flush.
- Storage is a circular buffer with wr_ptr/rd_ptr of log2(DEPTH) bits that wrap modulo DEPTH. Count is updated by +1, -1 or 0. A simultaneous enqueue and dequeue leaves count unchanged.
- in_ready is derived from registered count only. It never depends on out_ready, so a full queue refuses input even when it is dequeuing in the same cycle.
- There is no bypass: an instruction written into an empty queue is visible on the next cycle.
- Predecode uses op=instr[31:26], rt=[20:16], funct=[5:0]. Class bits:
  - [0] branch: op 000001, 000100–000111
  - [1] jump: op 000010/000011, or op 0 with funct 001000/001001
  - [2] load: op 100000, 100001, 100011, 100100, 100101
  - [3] store: op 101000, 101001, 101011
  - [4] hilo: op 0 with funct 010000–010011 or 011000–011011
  - [5] cp0: op 010000
  - [6] link: op 000011; op 000001 with rt 10000/10001; op 0 with funct 001001
  - [7] invalid: op not in {000000–001111, 010000, the load ops, the store ops}
- Delay-slot tracker: 1-bit register `last_cf`.
  - On every enqueue it is set to class[0] | class[1] of the enqueued instruction.
  - The ds bit stored with an enqueued entry is the value of last_cf before that update.
  - It is unaffected by dequeue.
- flush has priority over everything. Next cycle: count=0, pointers=0, last_cf=0, any enqueue or dequeue in the flush cycle is discarded.
- Entry storage is not cleared by flush or reset. Outputs are masked by out_valid.

## Timing
- Reset (resetn=0, asynchronous): count=0, pointers=0, last_cf=0, in_ready=1, out_valid=0, out_instr/out_pc/out_class/out_ds=0.
- Release of resetn is synchronised externally. The first enqueue can occur on the first rising edge with resetn=1.
- Enqueue-to-out_valid latency is 1 cycle. Sustained throughput is 1 instruction/cycle when 0 < count < DEPTH.
- Full: in_ready=0 the cycle after count reaches DEPTH. in_ready returns to 1 the cycle after a dequeue.
- Empty: out_valid=0 and out_ready is ignored; count never underflows.
- Reset asserted mid-operation drops all contents immediately, without waiting for an edge.

## Test plan
- Reset, then enqueue 0x24080005 (ADDIU) at pc 0xBFC00000 → next cycle out_valid=1, out_class=0x00, out_ds=0, count=1.
- DEPTH=4: enqueue 5 back-to-back with out_ready=0 → in_ready falls after the 4th, the 5th is held, count=4. Then one dequeue → the 5th is accepted on the following cycle and the wrap-around order is preserved.
- Enqueue 0x10000003 (BEQ), 0x00000000 (NOP), 0x8C820000 (LW):
  - BEQ → class 0x01, ds=0
  - NOP → ds=1
  - LW → class 0x04, ds=0
- Enqueue 0x0C000010 (JAL) → class 0x42. Enqueue 0x0411FFFF (BGEZAL) → class 0x41. Enqueue 0x00000018 (MULT) → class 0x10. Enqueue 0xFC000000 → class 0x80.
- With count=3 and in_valid & out_ready high, assert flush → next cycle count=0, out_valid=0, and the next enqueued instruction has ds=0 even if the flushed tail was a branch.
- Pulse resetn low between clock edges while count=2 → out_valid and count drop to 0 immediately, before the next edge.
